pipe_stall_sequencer: RTL and testbench

- Central stall/flush scheduler for the 5-stage SIMPLE pipeline.
- Takes the load-use hazard flag from the hazard detector, the EX-stage branch-taken signal, the data-memory busy signal, and the HLT decode.
- Drives the PC write enable, the pipeline-register write enables, the IF/ID flush and the ID/EX bubble.
- Sequences memory-wait freezes, multi-cycle branch flushes and halt drain, and keeps a stall-cycle performance counter.

---
 rtl/simple_pipe_pkg.sv | 17 +
 rtl/pipe_stall_sequencer_sat_counter.sv | 34 +++
 rtl/pipe_stall_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pipe_stall_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/simple_pipe_pkg.sv
// Shared definitions for the SIMPLE pipeline stall/flush control and its debug/trace consumers.
package simple_pipe_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALT     = 3'd4
    } pipe_state_e;

    localparam int unsigned DEF_FLUSH_CYCLES = 1;
    localparam int unsigned DEF_DRAIN_CYCLES = 3;
    localparam int unsigned DEF_MEM_TIMEOUT  = 255;
    localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/pipe_stall_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clear_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Stall/flush scheduler for the 5-stage SIMPLE pipeline: memory freezes, branch flushes,
// halt drain and a saturating stall-cycle counter. Enables are a Mealy function of state and inputs.
module pipe_stall_sequencer
    import simple_pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             halted,
    output logic             mem_fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);
    localparam logic [8:0] TMO_LIMIT  = 9'(MEM_TIMEOUT);

    pipe_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;     // flush and drain never overlap, so they share one counter
    logic [7:0]  tmo_q, tmo_d;
    logic        fault_q, fault_d;
    logic        freeze;
    logic [8:0]  tmo_inc;

    assign tmo_inc = {1'b0, tmo_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        fault_d      = fault_q;
        freeze       = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        halted       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    freeze  = 1'b1;
                    tmo_d   = 8'd1;
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (halt_req) begin
                    pc_we       = 1'b0;
                    if_id_flush = 1'b1;
                    cnt_d       = DRAIN_LOAD;
                    state_d     = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                // Other requests wait: the held pipeline re-presents them in RUN.
                freeze = 1'b1;
                if (!mem_busy) begin
                    tmo_d   = 8'd0;
                    state_d = ST_RUN;
                end else begin
                    tmo_d = tmo_inc[7:0];
                    if (tmo_inc >= TMO_LIMIT) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_FLUSH, ST_DRAIN: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    pc_we        = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = (state_q == ST_FLUSH) ? ST_RUN : ST_HALT;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            ST_HALT: begin
                freeze = 1'b1;
                halted = 1'b1;
                if (resume) begin
                    fault_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                freeze  = 1'b1;
                cnt_d   = 3'd0;
                tmo_d   = 8'd0;
                state_d = ST_RUN;
            end
        endcase

        if (freeze) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            tmo_q   <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (!pc_we && (state_q != ST_HALT)),
        .clear_i (1'b0),
        .count_o (stall_cycles)
    );

    assign mem_fault = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Scoreboard bench for pipe_stall_sequencer with FLUSH_CYCLES=3, DRAIN_CYCLES=3, MEM_TIMEOUT=4, CNT_W=5.
module tb_pipe_stall_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_use = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic       pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted, mem_fault;
    logic [2:0] state;
    logic [4:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_stall_sequencer #(
        .FLUSH_CYCLES (3),
        .DRAIN_CYCLES (3),
        .MEM_TIMEOUT  (4),
        .CNT_W        (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .halted       (halted),
        .mem_fault    (mem_fault),
        .state        (state),
        .stall_cycles (stall_cycles)
    );

    // Control vector bit order: {pc, if_id_we, flush, bubble, ex_mem, mem_wb, halted, fault}
    localparam logic [7:0] C_IDLE  = 8'b1100_1100;
    localparam logic [7:0] C_FRZ   = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b0001_1100;
    localparam logic [7:0] C_BR    = 8'b1111_1100;
    localparam logic [7:0] C_FL    = 8'b0111_1100;
    localparam logic [7:0] C_HREQ  = 8'b0110_1100;
    localparam logic [7:0] C_HALT  = 8'b0000_0010;
    localparam logic [7:0] C_HALTF = 8'b0000_0011;

    typedef struct {
        string      nm;
        logic [7:0] ctl;
        logic [2:0] st;
        logic [4:0] stall;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] act_ctl;

    task automatic step(input string nm, input logic r, input logic lu, input logic br,
                        input logic mb, input logic hr, input logic rs,
                        input logic [7:0] ctl, input logic [2:0] st, input int stall);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; load_use = lu; branch_taken = br; mem_busy = mb; halt_req = hr; resume = rs;
        e.nm = nm; e.ctl = ctl; e.st = st; e.stall = 5'(stall);
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                act_ctl = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, halted, mem_fault};
                checks++;
                if (act_ctl !== me.ctl) begin
                    errors++;
                    $display("FAIL %s ctl got %b want %b", me.nm, act_ctl, me.ctl);
                end
                checks++;
                if (state !== me.st) begin
                    errors++;
                    $display("FAIL %s state got %0d want %0d", me.nm, state, me.st);
                end
                checks++;
                if (stall_cycles !== me.stall) begin
                    errors++;
                    $display("FAIL %s stall got %0d want %0d", me.nm, stall_cycles, me.stall);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired with %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        //    name        rst lu br mb hr rs  ctl      st stall
        step("reset",      1, 0, 0, 0, 0, 0, C_IDLE,  0, 0);
        step("idle",       0, 0, 0, 0, 0, 0, C_IDLE,  0, 0);
        step("lu",         0, 1, 0, 0, 0, 0, C_LU,    0, 0);
        step("lu_after",   0, 0, 0, 0, 0, 0, C_IDLE,  0, 1);
        step("br",         0, 0, 1, 0, 0, 0, C_BR,    0, 1);
        step("br_fl1",     0, 0, 0, 0, 0, 0, C_FL,    2, 1);
        step("br_fl2",     0, 0, 0, 0, 0, 0, C_FL,    2, 2);
        step("br_done",    0, 0, 0, 0, 0, 0, C_IDLE,  0, 3);
        step("mb_run",     0, 0, 1, 1, 0, 0, C_FRZ,   0, 3);
        step("mb_w1",      0, 0, 1, 1, 0, 0, C_FRZ,   1, 4);
        step("mb_w2",      0, 0, 1, 1, 0, 0, C_FRZ,   1, 5);
        step("mb_exit",    0, 0, 1, 0, 0, 0, C_FRZ,   1, 6);
        step("mb_br",      0, 0, 1, 0, 0, 0, C_BR,    0, 7);
        step("mb_fl1",     0, 0, 0, 0, 0, 0, C_FL,    2, 7);
        step("mb_fl2",     0, 0, 0, 0, 0, 0, C_FL,    2, 8);
        step("mb_done",    0, 0, 0, 0, 0, 0, C_IDLE,  0, 9);
        step("fb_br",      0, 0, 1, 0, 0, 0, C_BR,    0, 9);
        step("fb_busy",    0, 0, 0, 1, 0, 0, C_FRZ,   2, 9);
        step("fb_fl1",     0, 0, 0, 0, 0, 0, C_FL,    2, 10);
        step("fb_fl2",     0, 0, 0, 0, 0, 0, C_FL,    2, 11);
        step("fb_done",    0, 0, 0, 0, 0, 0, C_IDLE,  0, 12);
        step("pri_br_lu",  0, 1, 1, 0, 0, 0, C_BR,    0, 12);
        step("pri_fl1",    0, 1, 0, 0, 0, 0, C_FL,    2, 12);
        step("pri_fl2",    0, 0, 0, 0, 0, 0, C_FL,    2, 13);
        step("pri_done",   0, 0, 0, 0, 0, 0, C_IDLE,  0, 14);
        step("to_1",       0, 0, 0, 1, 0, 0, C_FRZ,   0, 14);
        step("to_2",       0, 0, 0, 1, 0, 0, C_FRZ,   1, 15);
        step("to_3",       0, 0, 0, 1, 0, 0, C_FRZ,   1, 16);
        step("to_4",       0, 0, 0, 1, 0, 0, C_FRZ,   1, 17);
        step("to_halt",    0, 0, 0, 1, 0, 0, C_HALTF, 4, 18);
        step("to_ignore",  0, 1, 1, 1, 1, 0, C_HALTF, 4, 18);
        step("to_resume",  0, 0, 0, 0, 0, 1, C_HALTF, 4, 18);
        step("to_run",     0, 0, 0, 0, 0, 0, C_IDLE,  0, 18);
        step("hr",         0, 0, 0, 0, 1, 0, C_HREQ,  0, 18);
        step("dr_1",       0, 0, 0, 0, 0, 0, C_FL,    3, 19);
        step("dr_busy",    0, 0, 0, 1, 0, 0, C_FRZ,   3, 20);
        step("dr_2",       0, 0, 0, 0, 0, 0, C_FL,    3, 21);
        step("dr_3",       0, 0, 0, 0, 0, 0, C_FL,    3, 22);
        step("dr_halt",    0, 0, 0, 0, 0, 0, C_HALT,  4, 23);
        step("dr_hold",    0, 0, 0, 0, 1, 0, C_HALT,  4, 23);
        step("dr_resume",  0, 0, 0, 0, 0, 1, C_HALT,  4, 23);
        step("dr_run",     0, 0, 0, 0, 0, 0, C_IDLE,  0, 23);
        for (int i = 0; i < 10; i++) begin
            step("sat_lu",  0, 1, 0, 0, 0, 0, C_LU,    0, (23 + i > 31) ? 31 : 23 + i);
        end
        step("sat_idle",   0, 0, 0, 0, 0, 0, C_IDLE,  0, 31);
        step("rd_hr",      0, 0, 0, 0, 1, 0, C_HREQ,  0, 31);
        step("rd_dr1",     0, 0, 0, 0, 0, 0, C_FL,    3, 31);
        step("rd_rst",     1, 0, 0, 0, 0, 0, C_IDLE,  0, 0);
        step("rd_idle",    0, 0, 0, 0, 0, 0, C_IDLE,  0, 0);
        step("rd_lu",      0, 1, 0, 0, 0, 0, C_LU,    0, 0);
        step("rd_after",   0, 0, 0, 0, 0, 0, C_IDLE,  0, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard pending %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
